// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: bus widths, FSM states and access op encoding.
// Imported by the memory interface and available to the MAR/MDR blocks.
package mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    // Wide enough to hold LATENCY itself, the value reached on the completing edge.
    function automatic int cnt_width(input int latency);
        return $clog2(latency) + 1;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port DEPTH x DATA_W word memory: synchronous write, read data follows the address
// so the caller can capture it into its own register on the completing edge.
module ram_array #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 32,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would turn the RAM into a huge flop bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_interface.sv
// Memory stage behind the MAR: latches one Read/Write request, waits LATENCY cycles,
// performs the RAM access, then pulses Done for one cycle before accepting the next request.
module mem_interface #(
    parameter int ADDR_W  = mem_pkg::ADDR_W,
    parameter int DATA_W  = mem_pkg::DATA_W,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] Address,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Busy
);

    import mem_pkg::*;

    localparam int CNT_W  = cnt_width(LATENCY);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    op_t                 op_q;
    logic                in_range;
    logic                complete;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    assign in_range = (32'(addr_q) < DEPTH);
    assign complete = (state == ACCESS) && (count == LAST);
    // Out-of-range writes are dropped here; the access still completes normally.
    assign ram_we   = complete && (op_q == OP_WRITE) && in_range;

    ram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Read || Write) state_nx = ACCESS;
            ACCESS:  if (count == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state != IDLE);
        Done = (state == DONE);
    end

    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            count   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= OP_READ;
            DataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Read || Write) begin
                        addr_q <= Address;
                        data_q <= DataIn;
                        op_q   <= Write ? OP_WRITE : OP_READ;
                        count  <= '0;
                    end
                end
                ACCESS: begin
                    count <= count + 1'b1;
                    if (complete && (op_q == OP_READ)) begin
                        DataOut <= in_range ? ram_rdata : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench: three mem_interface instances (LATENCY 2/1/4, DEPTH 512/512/256) share
// one stimulus stream and are compared every cycle against an edge-count reference model.
module tb_mem_interface;

    logic        clk = 1'b0;
    logic        Clear;
    logic        Read;
    logic        Write;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] dout [3];
    logic        done_s [3];
    logic        busy_s [3];

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_interface #(.LATENCY(2), .DEPTH(512)) dut (
        .clk(clk), .Clear(Clear), .Address(Address), .Read(Read), .Write(Write),
        .DataIn(DataIn), .DataOut(dout[0]), .Done(done_s[0]), .Busy(busy_s[0])
    );

    mem_interface #(.LATENCY(1), .DEPTH(512)) dut_l1 (
        .clk(clk), .Clear(Clear), .Address(Address), .Read(Read), .Write(Write),
        .DataIn(DataIn), .DataOut(dout[1]), .Done(done_s[1]), .Busy(busy_s[1])
    );

    mem_interface #(.LATENCY(4), .DEPTH(256)) dut_l4 (
        .clk(clk), .Clear(Clear), .Address(Address), .Read(Read), .Write(Write),
        .DataIn(DataIn), .DataOut(dout[2]), .Done(done_s[2]), .Busy(busy_s[2])
    );

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, inst, $time, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference model: each request is tracked by the edge number on which it completes.
    int          lat [3] = '{2, 1, 4};
    int          dep [3] = '{512, 512, 256};
    logic [31:0] mmem [3][512];
    bit          pend [3];
    int          done_edge [3];
    bit          pop_w [3];
    logic [8:0]  paddr [3];
    logic [31:0] pdata [3];
    logic [31:0] exp_do [3];
    bit          exp_done [3];
    bit          exp_busy [3];
    int          edge_n = 0;

    always @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 3; i++) begin
                pend[i]     = 1'b0;
                exp_do[i]   = '0;
                exp_done[i] = 1'b0;
                exp_busy[i] = 1'b0;
            end
        end else begin
            edge_n++;
            for (int i = 0; i < 3; i++) begin
                if (pend[i] && edge_n == done_edge[i] + 1) begin
                    pend[i] = 1'b0;
                end else if (pend[i] && edge_n == done_edge[i]) begin
                    if (pop_w[i]) begin
                        if (int'(paddr[i]) < dep[i]) mmem[i][paddr[i]] = pdata[i];
                    end else begin
                        exp_do[i] = (int'(paddr[i]) < dep[i]) ? mmem[i][paddr[i]] : 32'h0;
                    end
                end else if (!pend[i] && (Read || Write)) begin
                    pend[i]      = 1'b1;
                    done_edge[i] = edge_n + lat[i];
                    pop_w[i]     = Write;
                    paddr[i]     = Address;
                    pdata[i]     = DataIn;
                end
                exp_busy[i] = pend[i];
                exp_done[i] = pend[i] && (edge_n == done_edge[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                check("dataout", i, dout[i], exp_do[i]);
                check("done", i, 32'(done_s[i]), 32'(exp_done[i]));
                check("busy", i, 32'(busy_s[i]), 32'(exp_busy[i]));
            end
        end
    end

    logic [8:0]  pool [12] = '{9'h000, 9'h005, 9'h010, 9'h011, 9'h020, 9'h0FF,
                               9'h100, 9'h1A0, 9'h1FF, 9'h0AA, 9'h155, 9'h001};
    logic [31:0] pool_data [12];

    task automatic req(input bit r, input bit w, input logic [8:0] a, input logic [31:0] d);
        @(posedge clk); #2;
        Read = r; Write = w; Address = a; DataIn = d;
        @(posedge clk); #2;
        Read = 1'b0; Write = 1'b0; Address = 9'($urandom); DataIn = $urandom;
    endtask

    // Called right after req(): Done must appear in cycle LATENCY+1 after the request edge.
    task automatic measure(input string name);
        int first [3] = '{0, 0, 0};
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done_s[i] && first[i] == 0) first[i] = n;
            end
        end
        check(name, 0, first[0], 3);
        check(name, 1, first[1], 2);
        check(name, 2, first[2], 5);
    endtask

    task automatic count_done(input string name, input int exp_pulses);
        int pulses [3] = '{0, 0, 0};
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done_s[i]) pulses[i]++;
            end
        end
        for (int i = 0; i < 3; i++) check(name, i, pulses[i], exp_pulses);
    endtask

    initial begin
        Clear = 1'b0; Read = 1'b0; Write = 1'b0; Address = '0; DataIn = '0;

        // Reset, then idle with no strobes.
        repeat (2) @(posedge clk);
        #2 Clear = 1'b1;
        cmp_en = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check("idle_dataout", i, dout[i], 32'h0);
                check("idle_done", i, 32'(done_s[i]), 32'h0);
                check("idle_busy", i, 32'(busy_s[i]), 32'h0);
            end
        end

        // Give every pool address a known value in every instance.
        for (int p = 0; p < 12; p++) begin
            pool_data[p] = $urandom;
            req(1'b0, 1'b1, pool[p], pool_data[p]);
            repeat (7) @(posedge clk);
        end

        // Write then read back; the write must not disturb DataOut.
        req(1'b0, 1'b1, 9'h005, 32'hDEADBEEF);
        measure("write_latency");
        for (int i = 0; i < 3; i++) check("write_keeps_dataout", i, dout[i], 32'h0);
        req(1'b1, 1'b0, 9'h005, 32'h0);
        measure("read_latency");
        for (int i = 0; i < 3; i++) check("read_005", i, dout[i], 32'hDEADBEEF);

        // Second read issued while busy is ignored.
        @(posedge clk); #2;
        Read = 1'b1; Address = 9'h010;
        @(posedge clk); #2;
        Address = 9'h011;
        @(posedge clk); #2;
        Read = 1'b0;
        count_done("ignored_done_pulses", 1);
        for (int i = 0; i < 3; i++) check("read_010", i, dout[i], pool_data[2]);

        // Read and Write together behave as a Write.
        req(1'b1, 1'b1, 9'h1FF, 32'h12345678);
        repeat (8) @(posedge clk);
        req(1'b1, 1'b0, 9'h1FF, 32'h0);
        measure("read_1ff_latency");
        check("read_1ff", 0, dout[0], 32'h12345678);
        check("read_1ff", 1, dout[1], 32'h12345678);
        check("read_1ff", 2, dout[2], 32'h0);

        // Reset during ACCESS aborts the write.
        req(1'b0, 1'b1, 9'h020, 32'hCAFEF00D);
        #1 Clear = 1'b0;
        @(posedge clk); #2 Clear = 1'b1;
        count_done("aborted_done_pulses", 0);
        req(1'b1, 1'b0, 9'h020, 32'h0);
        measure("read_020_latency");
        for (int i = 0; i < 3; i++) check("read_020_kept", i, dout[i], pool_data[4]);

        // Address beyond the smaller DEPTH reads as zero there only.
        req(1'b1, 1'b0, 9'h1A0, 32'h0);
        measure("read_1a0_latency");
        check("read_1a0", 0, dout[0], pool_data[7]);
        check("read_1a0", 1, dout[1], pool_data[7]);
        check("read_1a0_out_of_range", 2, dout[2], 32'h0);

        // Random traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            Read    = ($urandom_range(3) == 0);
            Write   = ($urandom_range(4) == 0);
            Address = pool[$urandom_range(11)];
            DataIn  = $urandom;
            if ($urandom_range(399) == 0) begin
                #1 Clear = 1'b0;
                #1 Clear = 1'b1;
            end
        end
        @(posedge clk); #2;
        Read = 1'b0; Write = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
